alu_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 16-bit processor ALU. It accepts operation requests (opcode, A, B) from two masters, the instruction control unit on port 0 and the sampling engine on port 1. It drives the ALU's `control`/`A`/`B` inputs and holds them until the ALU's 5-stage delayed zero flag is valid. It then returns the result and zero flag to the granted master with a one-cycle `done` pulse.

---
 rtl/alu_arbiter_pkg.sv | 35 +++
 rtl/alu_rr_pick.sv | 22 ++
 rtl/alu_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode constants, zero-flag latency,
// FSM state encoding and the legal-opcode check.
package alu_arbiter_pkg;

  localparam int ALU_Z_LAT = 5;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_01  = 5'b00001;
  localparam logic [4:0] OP_02  = 5'b00010;
  localparam logic [4:0] OP_03  = 5'b00011;
  localparam logic [4:0] OP_04  = 5'b00100;
  localparam logic [4:0] OP_05  = 5'b00101;
  localparam logic [4:0] OP_06  = 5'b00110;
  localparam logic [4:0] OP_07  = 5'b00111;
  localparam logic [4:0] OP_ADD = 5'b01000;
  localparam logic [4:0] OP_SUB = 5'b01001;
  localparam logic [4:0] OP_0A  = 5'b01010;
  localparam logic [4:0] OP_0B  = 5'b01011;
  localparam logic [4:0] OP_1C  = 5'b11100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_01, OP_02, OP_03, OP_04, OP_05, OP_06, OP_07,
      OP_ADD, OP_SUB, OP_0A, OP_0B, OP_1C: op_legal = 1'b1;
      default:                             op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: the port other than `last` wins a tie, a sole
// eligible requester always wins.
module alu_rr_pick (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic [1:0] gnt
);

  logic [1:0] elig_s;

  // Grant selection from the eligible request vector
  always_comb begin
    elig_s = req & ~mask;
    if (elig_s == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = elig_s;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two masters onto the ALU, holds its inputs until the delayed zero
// flag is valid, then returns result/zero/err with a one-cycle done pulse.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W     = 16,
  parameter int Z_LAT = ALU_Z_LAT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [4:0]   op0,
  input  logic [4:0]   op1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         err,
  output logic         busy,
  output logic [4:0]   alu_ctrl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_data,
  input  logic         alu_z
);

  localparam int            CW       = (Z_LAT < 1) ? 1 : $clog2(Z_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(Z_LAT);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           port_q, port_d;
  logic           mask_q, mask_d;
  logic [4:0]     ctrl_q, ctrl_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   result_q, result_d;
  logic           zero_q, zero_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           done0_q, done0_d;
  logic           done1_q, done1_d;

  logic [1:0]     mask_s;
  logic [1:0]     gnt_s;
  logic           sel_s;
  logic [4:0]     sel_op_s;
  logic [W-1:0]   sel_a_s;
  logic [W-1:0]   sel_b_s;

  // The port served last is ineligible for the one IDLE cycle following DONE
  assign mask_s   = mask_q ? (port_q ? 2'b10 : 2'b01) : 2'b00;
  assign sel_s    = gnt_s[1];
  assign sel_op_s = sel_s ? op1 : op0;
  assign sel_a_s  = sel_s ? a1 : a0;
  assign sel_b_s  = sel_s ? b1 : b0;

  alu_rr_pick u_pick (
    .req  ({req1, req0}),
    .mask (mask_s),
    .last (last_q),
    .gnt  (gnt_s)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    port_d   = port_q;
    mask_d   = 1'b0;
    ctrl_d   = ctrl_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          port_d = sel_s;
          last_d = sel_s;
          busy_d = 1'b1;
          if (op_legal(sel_op_s)) begin
            state_d = ST_EXEC;
            cnt_d   = {CW{1'b0}};
            ctrl_d  = sel_op_s;
            opa_d   = sel_a_s;
            opb_d   = sel_b_s;
          end else begin
            // Illegal opcodes never reach the ALU and complete at once
            state_d  = ST_DONE;
            result_d = {W{1'b0}};
            zero_d   = 1'b0;
            err_d    = 1'b1;
            done0_d  = ~sel_s;
            done1_d  = sel_s;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          cnt_d    = {CW{1'b0}};
          result_d = alu_data;
          zero_d   = alu_z;
          err_d    = 1'b0;
          done0_d  = ~port_q;
          done1_d  = port_q;
          ctrl_d   = OP_NOP;
          opa_d    = {W{1'b0}};
          opb_d    = {W{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        mask_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ctrl_d  = OP_NOP;
        opa_d   = {W{1'b0}};
        opb_d   = {W{1'b0}};
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      mask_q   <= 1'b0;
      ctrl_q   <= OP_NOP;
      opa_q    <= {W{1'b0}};
      opb_q    <= {W{1'b0}};
      result_q <= {W{1'b0}};
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      port_q   <= port_d;
      mask_q   <= mask_d;
      ctrl_q   <= ctrl_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign alu_ctrl = ctrl_q;
  assign alu_a    = opa_q;
  assign alu_b    = opb_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a stub ALU with a delayed zero flag, a
// timeline-level reference model compared every cycle, and pinned literals.
module tb_alu_arbiter;

  localparam int W  = 16;
  localparam int ZL = 5;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         req [2];
  logic [4:0]   op  [2];
  logic [W-1:0] av  [2];
  logic [W-1:0] bv  [2];
  logic         done0, done1, zero, err, busy, alu_z;
  logic [W-1:0] result, alu_a, alu_b, alu_data;
  logic [4:0]   alu_ctrl;
  logic [ZL-1:0] zp = '0;

  int errors = 0;
  int checks = 0;
  int served[$];

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .Z_LAT(ZL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .op0(op[0]), .op1(op[1]),
    .a0(av[0]), .b0(bv[0]), .a1(av[1]), .b1(bv[1]),
    .done0(done0), .done1(done1), .result(result), .zero(zero), .err(err),
    .busy(busy), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_data(alu_data), .alu_z(alu_z)
  );

  function automatic logic [W-1:0] alu_f(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      5'b01000: return x + y;
      5'b01001: return x - y;
      5'b00001: return x & y;
      5'b00010: return x | y;
      5'b00011: return x ^ y;
      default:  return x;
    endcase
  endfunction

  function automatic bit legal_f(input logic [4:0] o);
    return ((o >= 5'd1) && (o <= 5'd11)) || (o == 5'd28);
  endfunction

  // Stub ALU: combinational result, zero flag delayed by ZL clocks
  assign alu_data = alu_f(alu_ctrl, alu_a, alu_b);
  always @(posedge clk) zp <= {zp[ZL-2:0], (alu_data == '0)};
  assign alu_z = zp[ZL-1];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Reference model: each grant is a time window [g, d] on the edge count
  int k = 0, free_edge = 0, g_edge = 0, d_edge = 0, mask_edge = -10;
  int m_port = 0, last_m = 1, mask_port = 0;
  bit act = 1'b0, m_legal = 1'b0, el0, el1, inex;
  logic [4:0]   m_op = '0, e_ctrl = '0;
  logic [W-1:0] m_a = '0, m_b = '0, e_res = '0, e_a = '0, e_b = '0;
  logic         e_zero = 1'b0, e_err = 1'b0, e_busy = 1'b0, e_d0 = 1'b0, e_d1 = 1'b0;

  initial forever begin
    @(posedge clk);
    k++;
    if (!rst_n) begin
      act = 1'b0; last_m = 1; free_edge = 0; mask_edge = -10;
      e_res = '0; e_zero = 1'b0; e_err = 1'b0;
    end else begin
      if (act && k == d_edge + 1) begin
        act = 1'b0; free_edge = k + 1; mask_edge = k + 1; mask_port = m_port;
      end
      if (!act && k >= free_edge) begin
        el0 = req[0] && !(k == mask_edge && mask_port == 0);
        el1 = req[1] && !(k == mask_edge && mask_port == 1);
        if (el0 || el1) begin
          m_port = (el0 && el1) ? 1 - last_m : (el1 ? 1 : 0);
          last_m = m_port;
          m_op = op[m_port]; m_a = av[m_port]; m_b = bv[m_port];
          m_legal = legal_f(m_op);
          act = 1'b1; g_edge = k;
          d_edge = m_legal ? k + ZL + 1 : k;
        end
      end
      if (act && k == d_edge) begin
        e_res  = m_legal ? alu_f(m_op, m_a, m_b) : '0;
        e_zero = m_legal && (e_res == '0);
        e_err  = !m_legal;
      end
    end
    e_busy = rst_n && act && k <= d_edge;
    inex   = rst_n && act && m_legal && k <= g_edge + ZL;
    e_ctrl = inex ? m_op : 5'd0;
    e_a    = inex ? m_a : '0;
    e_b    = inex ? m_b : '0;
    e_d0   = rst_n && act && k == d_edge && m_port == 0;
    e_d1   = rst_n && act && k == d_edge && m_port == 1;
  end

  // Per-cycle comparison against the model, mid-cycle
  initial forever begin
    @(negedge clk);
    chk("busy",     busy,     rst_n ? e_busy : 1'b0);
    chk("done0",    done0,    rst_n ? e_d0 : 1'b0);
    chk("done1",    done1,    rst_n ? e_d1 : 1'b0);
    chk("result",   result,   rst_n ? e_res : '0);
    chk("zero",     zero,     rst_n ? e_zero : 1'b0);
    chk("err",      err,      rst_n ? e_err : 1'b0);
    chk("alu_ctrl", alu_ctrl, rst_n ? e_ctrl : 5'd0);
    chk("alu_a",    alu_a,    rst_n ? e_a : '0);
    chk("alu_b",    alu_b,    rst_n ? e_b : '0);
    if (done0 === 1'b1) served.push_back(0);
    if (done1 === 1'b1) served.push_back(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int p, output int lat, output int cc);
    logic d;
    lat = 0; cc = 0; d = 1'b0;
    while (!d && lat < 40) begin
      tick();
      lat++;
      if (alu_ctrl != 5'd0) cc++;
      d = (p == 0) ? done0 : done1;
    end
    if (!d) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_one(input int p, input logic [4:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, output int lat, output int cc);
    req[p] = 1'b1; op[p] = o; av[p] = x; bv[p] = y;
    wait_done(p, lat, cc);
    req[p] = 1'b0;
  endtask

  task automatic master(input int p, input int n);
    int lat, cc;
    for (int i = 0; i < n; i++) begin
      run_one(p, 5'b01000, W'(p + i), W'(2), lat, cc);
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  int lat0, lat1, cc0, cc1, sz;

  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; op[p] = 5'd0; av[p] = '0; bv[p] = '0;
    end
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_ctrl", alu_ctrl, 5'd0);
    do_reset();

    // Single ADD on port 0: 7-cycle latency, ALU held for 6 cycles
    run_one(0, 5'b01000, 16'd3, 16'd4, lat0, cc0);
    chk("add_latency", lat0, 32'd7);
    chk("add_ctrl_cycles", cc0, 32'd6);
    chk("add_result", result, 16'd7);
    chk("add_zero", zero, 1'b0);
    chk("add_err", err, 1'b0);
    repeat (2) tick();

    // Illegal NOP: completes the cycle after grant, result cleared
    run_one(0, 5'b00000, 16'd9, 16'd9, lat0, cc0);
    chk("nop_latency", lat0, 32'd1);
    chk("nop_ctrl_cycles", cc0, 32'd0);
    chk("nop_err", err, 1'b1);
    chk("nop_result", result, 16'd0);
    repeat (2) tick();

    // SUB 5-5 on port 1: zero flag through the delayed pipeline
    run_one(1, 5'b01001, 16'd5, 16'd5, lat1, cc1);
    chk("sub_latency", lat1, 32'd7);
    chk("sub_result", result, 16'd0);
    chk("sub_zero", zero, 1'b1);
    chk("sub_err", err, 1'b0);
    repeat (2) tick();

    // Illegal 10001 on port 1
    run_one(1, 5'b10001, 16'd1, 16'd2, lat1, cc1);
    chk("ill_latency", lat1, 32'd1);
    chk("ill_err", err, 1'b1);
    chk("ill_ctrl_cycles", cc1, 32'd0);
    repeat (2) tick();

    // Port 0 served alone, so a following tie goes to port 1
    run_one(0, 5'b00011, 16'hF0F0, 16'h0FF0, lat0, cc0);
    chk("xor_result", result, 16'hFF00);
    repeat (2) tick();
    fork
      run_one(0, 5'b01000, 16'd10, 16'd20, lat0, cc0);
      run_one(1, 5'b01000, 16'd1, 16'd2, lat1, cc1);
    join
    chk("tie_last_p1_lat", lat1, 32'd7);
    chk("tie_last_p0_lat", lat0, 32'd15);
    chk("tie_last_result", result, 16'd30);
    repeat (2) tick();

    // After reset the first tie goes to port 0, then service alternates
    do_reset();
    served.delete();
    fork
      master(0, 3);
      master(1, 3);
    join
    sz = served.size();
    chk("alt_count", sz, 32'd6);
    for (int i = 0; i < sz; i++) chk("alt_order", served[i], i % 2);
    repeat (2) tick();

    // Mask window: req0 held through the masked cycle, then dropped
    req[0] = 1'b1; op[0] = 5'b01000; av[0] = 16'd6; bv[0] = 16'd7;
    wait_done(0, lat0, cc0);
    tick();
    tick();
    chk("mask_no_regrant", busy, 1'b0);
    req[0] = 1'b0;
    tick();
    chk("mask_dropped_idle", busy, 1'b0);
    repeat (2) tick();

    // Mask window: req0 held continuously, re-granted one cycle after mask
    req[0] = 1'b1; av[0] = 16'd100; bv[0] = 16'd23;
    wait_done(0, lat0, cc0);
    chk("hold_first_lat", lat0, 32'd7);
    wait_done(0, lat0, cc0);
    chk("hold_second_gap", lat0, 32'd9);
    chk("hold_result", result, 16'd123);
    req[0] = 1'b0;
    repeat (2) tick();

    // Reset at cnt=3 aborts the operation with no done
    served.delete();
    req[1] = 1'b1; op[1] = 5'b01000; av[1] = 16'd2; bv[1] = 16'd2;
    repeat (4) tick();
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_ctrl", alu_ctrl, 5'b01000);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ctrl", alu_ctrl, 5'd0);
    chk("rst_alu_a", alu_a, 16'd0);
    chk("rst_result", result, 16'd123 & 16'd0);
    req[1] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_idle", busy, 1'b0);
    sz = served.size();
    chk("post_rst_no_done", sz, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
